// File: rtl/rv_bypass_ctrl_if.sv
// ============================================================================
// Module   : rv_bypass_ctrl_if
// Brief    : Decode-side interface of the bypass/hazard controller: issue info,
//            source operands, forwarding selects and load-use stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rv_bypass_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    // One-hot forwarding select, youngest stage in the MSB.
    typedef struct packed {
        logic alu2;
        logic write;
        logic wr_back;
    } ctrl_rs_bp_t;

    logic                  i_hold;
    logic                  i_flush;
    logic                  i_issue_valid;
    logic [REG_ADDR_W-1:0] i_issue_rd;
    logic                  i_issue_rd_wr;
    logic                  i_issue_load;
    logic [REG_ADDR_W-1:0] i_rs1;
    logic [REG_ADDR_W-1:0] i_rs2;
    ctrl_rs_bp_t           o_rs1_bp;
    ctrl_rs_bp_t           o_rs2_bp;
    logic                  o_load_stall;

    modport master (
        output i_hold, i_flush, i_issue_valid, i_issue_rd, i_issue_rd_wr,
               i_issue_load, i_rs1, i_rs2,
        input  o_rs1_bp, o_rs2_bp, o_load_stall
    );

    modport slave (
        input  i_hold, i_flush, i_issue_valid, i_issue_rd, i_issue_rd_wr,
               i_issue_load, i_rs1, i_rs2,
        output o_rs1_bp, o_rs2_bp, o_load_stall
    );
endinterface

`default_nettype wire

// File: rtl/rv_bypass_ctrl.sv
// ============================================================================
// Module   : rv_bypass_ctrl
// Brief    : Tracks destination regs of in-flight instrs (ALU2 -> WRITE ->
//            WR_BACK) and drives one-hot rs1/rs2 forwarding selects plus a
//            load-use stall. Optional macro RV_BP_WR_BACK_EN builds the
//            WR_BACK slot; otherwise the wr_back selects are tied to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_bypass_ctrl #(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset,
    rv_bypass_ctrl_if.slave     bus
);

    localparam logic [REG_ADDR_W-1:0] c_X0 = '0;

    // ALU2 slot: only this slot needs the load flag, older slots already hold data.
    logic                  r_a_v;
    logic [REG_ADDR_W-1:0] r_a_rd;
    logic                  r_a_ld;
    logic                  r_w_v;
    logic [REG_ADDR_W-1:0] r_w_rd;
    logic                  w_b_v;
    logic [REG_ADDR_W-1:0] w_b_rd;

    logic                  w_new_v;
    logic [3:0]            w_sel1;
    logic [3:0]            w_sel2;
    logic                  w_stall;

    // Returns {load_hit, alu2, write, wr_back} for one source operand.
    function automatic logic [3:0] f_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  a_v,
        input logic [REG_ADDR_W-1:0] a_rd,
        input logic                  a_ld,
        input logic                  w_v,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  b_v,
        input logic [REG_ADDR_W-1:0] b_rd
    );
        logic m_a, m_w, m_b, s_a, s_w, s_b;
        m_a = a_v && (a_rd == rs) && (rs != c_X0);
        m_w = w_v && (w_rd == rs) && (rs != c_X0);
        m_b = b_v && (b_rd == rs) && (rs != c_X0);
        s_a = m_a && !a_ld;
        s_w = m_w && !s_a;
        s_b = m_b && !s_a && !s_w;
        return {m_a && a_ld, s_a, s_w, s_b};
    endfunction

    assign w_new_v = bus.i_issue_valid && bus.i_issue_rd_wr &&
                     (bus.i_issue_rd != c_X0) && !w_stall && !bus.i_flush;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a_v  <= 1'b0;
            r_a_rd <= '0;
            r_a_ld <= 1'b0;
            r_w_v  <= 1'b0;
            r_w_rd <= '0;
        end else if (!bus.i_hold) begin
            r_w_v  <= r_a_v;
            r_w_rd <= r_a_rd;
            r_a_v  <= w_new_v;
            r_a_rd <= bus.i_issue_rd;
            r_a_ld <= bus.i_issue_load;
        end else if (bus.i_flush) begin
            r_a_v  <= 1'b0;
        end
    end

`ifdef RV_BP_WR_BACK_EN
    logic                  r_b_v;
    logic [REG_ADDR_W-1:0] r_b_rd;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_b_v  <= 1'b0;
            r_b_rd <= '0;
        end else if (!bus.i_hold) begin
            r_b_v  <= r_w_v;
            r_b_rd <= r_w_rd;
        end
    end

    assign w_b_v  = r_b_v;
    assign w_b_rd = r_b_rd;
`else
    // Register file write-through covers the WR_BACK distance.
    assign w_b_v  = 1'b0;
    assign w_b_rd = '0;
`endif

    assign w_sel1  = f_sel(bus.i_rs1, r_a_v, r_a_rd, r_a_ld, r_w_v, r_w_rd, w_b_v, w_b_rd);
    assign w_sel2  = f_sel(bus.i_rs2, r_a_v, r_a_rd, r_a_ld, r_w_v, r_w_rd, w_b_v, w_b_rd);
    assign w_stall = bus.i_issue_valid && !bus.i_flush && (w_sel1[3] || w_sel2[3]);

    assign bus.o_rs1_bp     = w_sel1[2:0];
    assign bus.o_rs2_bp     = w_sel2[2:0];
    assign bus.o_load_stall = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_rv_bypass_ctrl.sv
// ============================================================================
// Module   : tb_rv_bypass_ctrl
// Brief    : Directed vector table plus hand-written hold/reset sequence for
//            rv_bypass_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv_bypass_ctrl;

`ifdef RV_BP_WR_BACK_EN
    localparam logic [2:0] WBX = 3'b001;
`else
    localparam logic [2:0] WBX = 3'b000;
`endif

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 i_clk = ~i_clk;

    rv_bypass_ctrl_if #(.REG_ADDR_W(5)) bus ();

    rv_bypass_ctrl #(.REG_ADDR_W(5)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    typedef struct {
        logic       hold, flush, iv;
        logic [4:0] rd;
        logic       rdwr, ld;
        logic [4:0] rs1, rs2;
        logic [2:0] e1, e2;
        logic       es;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic hold, logic flush, logic iv, logic [4:0] rd,
                                logic rdwr, logic ld, logic [4:0] rs1, logic [4:0] rs2,
                                logic [2:0] e1, logic [2:0] e2, logic es);
        vec_t v;
        v.hold = hold; v.flush = flush; v.iv = iv; v.rd = rd; v.rdwr = rdwr; v.ld = ld;
        v.rs1 = rs1; v.rs2 = rs2; v.e1 = e1; v.e2 = e2; v.es = es;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic hold, logic flush, logic iv, logic [4:0] rd,
                         logic rdwr, logic ld, logic [4:0] rs1, logic [4:0] rs2);
        bus.i_hold = hold; bus.i_flush = flush; bus.i_issue_valid = iv;
        bus.i_issue_rd = rd; bus.i_issue_rd_wr = rdwr; bus.i_issue_load = ld;
        bus.i_rs1 = rs1; bus.i_rs2 = rs2;
    endtask

    initial begin
        logic [2:0] a1, a2;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        //         hold flush iv rd rdwr ld rs1 rs2  e1      e2      es
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 3'b000, 3'b000, 0));  // 0 reset state
        vecs.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0, 3'b000, 3'b000, 0));  // 1 add x5
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 3'b100, 3'b000, 0));  // 2
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 3'b010, 3'b000, 0));  // 3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, WBX,    3'b000, 0));  // 4
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 5, 3'b000, 3'b000, 0));  // 5
        vecs.push_back(mk(0, 0, 1, 7, 1, 1, 0, 0, 3'b000, 3'b000, 0));  // 6 lw x7
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 7, 3'b000, 3'b000, 1));  // 7 load-use
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 7, 3'b000, 3'b010, 0));  // 8 now from WRITE
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 3'b100, WBX,    0));  // 9
        vecs.push_back(mk(0, 0, 1, 3, 1, 0, 1, 0, 3'b010, 3'b000, 0));  // 10 issue x3
        vecs.push_back(mk(0, 0, 1, 3, 1, 0, 3, 1, 3'b100, WBX,    0));  // 11 issue x3 again
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3, 3, 3'b100, 3'b100, 0));  // 12 hold
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3, 3, 3'b100, 3'b100, 0));  // 13 hold
        vecs.push_back(mk(1, 0, 1, 8, 1, 0, 3, 3, 3'b100, 3'b100, 0));  // 14 hold, issue ignored
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8, 3, 3'b000, 3'b100, 0));  // 15
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 3'b010, 3'b000, 0));  // 16 youngest of W/B
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, WBX,    3'b000, 0));  // 17
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 3'b000, 0));  // 18 rd=x0
        vecs.push_back(mk(0, 1, 1, 9, 1, 0, 9, 0, 3'b000, 3'b000, 0));  // 19 flushed x9
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 3'b000, 3'b000, 0));  // 20
        vecs.push_back(mk(0, 0, 1, 6, 1, 0, 0, 0, 3'b000, 3'b000, 0));  // 21 issue x6
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 6, 6, 3'b100, 3'b100, 0));  // 22 hold+flush
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 6, 6, 3'b000, 3'b000, 0));  // 23 flush won
        vecs.push_back(mk(0, 0, 1, 4, 1, 1, 0, 0, 3'b000, 3'b000, 0));  // 24 lw x4
        vecs.push_back(mk(1, 0, 1, 2, 1, 0, 4, 0, 3'b000, 3'b000, 1));  // 25 stall held
        vecs.push_back(mk(1, 0, 1, 2, 1, 0, 4, 0, 3'b000, 3'b000, 1));  // 26 stall held
        vecs.push_back(mk(0, 0, 1, 2, 1, 0, 4, 0, 3'b000, 3'b000, 1));  // 27 unheld -> bubble
        vecs.push_back(mk(0, 0, 1, 4, 1, 1, 4, 4, 3'b010, 3'b010, 0));  // 28 lw x4 again
        vecs.push_back(mk(0, 1, 1, 2, 1, 0, 4, 0, WBX,    3'b000, 0));  // 29 flush blocks stall
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4, 4, 3'b010, 3'b010, 0));  // 30

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge i_clk);
            drive(vecs[i].hold, vecs[i].flush, vecs[i].iv, vecs[i].rd,
                  vecs[i].rdwr, vecs[i].ld, vecs[i].rs1, vecs[i].rs2);
            #1;
            a1 = bus.o_rs1_bp;
            a2 = bus.o_rs2_bp;
            chk($sformatf("v%0d rs1_bp", i), 32'(a1), 32'(vecs[i].e1));
            chk($sformatf("v%0d rs2_bp", i), 32'(a2), 32'(vecs[i].e2));
            chk($sformatf("v%0d stall", i), 32'(bus.o_load_stall), 32'(vecs[i].es));
        end

        // Load in ALU2 held, then asynchronous reset in the middle of the hold.
        @(negedge i_clk);
        drive(0, 0, 1, 4, 1, 1, 0, 0);
        @(negedge i_clk);
        drive(1, 0, 1, 2, 1, 0, 4, 0);
        #1;
        chk("hold1 stall", 32'(bus.o_load_stall), 32'd1);
        @(negedge i_clk);
        #1;
        chk("hold2 stall", 32'(bus.o_load_stall), 32'd1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("async rst stall", 32'(bus.o_load_stall), 32'd0);
        a1 = bus.o_rs1_bp;
        chk("async rst rs1_bp", 32'(a1), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 4, 4);
        @(negedge i_clk);
        #1;
        a1 = bus.o_rs1_bp;
        a2 = bus.o_rs2_bp;
        chk("post rst rs1_bp", 32'(a1), 32'd0);
        chk("post rst rs2_bp", 32'(a2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
